bram_port_arbiter: RTL and testbench

- Shares frame-buffer BRAM port A between N requesters: UART/com_to_mem, pattern_gen and imag_procesor.
- Replaces the static switch mux with handshake-based arbitration.
- Modes: round-robin, or exclusive to one switch-selected requester. Optional locked bursts.
- Routes write accesses to the BRAM and returns read data, with a valid strobe, to the requester that issued the read.

---
 rtl/bram_port_arbiter.sv | 200 ++++++++++++++++++++
 tb/tb_bram_port_arbiter.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bram_port_arbiter.sv
// +----------------------------------------------------------------------------+
// | bram_port_arbiter: handshake arbiter sharing frame-buffer BRAM port A       |
// | among N requesters (round-robin / exclusive, locked bursts).                |
// | Optional per-requester accept counters: define ARB_PERF_CNT_EN.             |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
`default_nettype none

module bram_port_arbiter #(
   parameter int N          = 3,
   parameter int ADDR_WIDTH = 17,
   parameter int DATA_WIDTH = 12,
   parameter int MAX_BURST  = 16
) (
   input  logic                    clk,
   input  logic                    i_reset_n,
   input  logic                    i_enable,
   input  logic                    i_mode,
   input  logic [$clog2(N)-1:0]    i_sel,
   input  logic [N-1:0]            i_req,
   input  logic [N-1:0]            i_we,
   input  logic [N-1:0]            i_lock,
   input  logic [N*ADDR_WIDTH-1:0] i_addr,
   input  logic [N*DATA_WIDTH-1:0] i_data,
   output logic [N-1:0]            o_gnt,
   output logic [N-1:0]            o_rvalid,
   output logic [DATA_WIDTH-1:0]   o_rdata,
   output logic                    o_bram_en,
   output logic                    o_bram_we,
   output logic [ADDR_WIDTH-1:0]   o_bram_addr,
   output logic [DATA_WIDTH-1:0]   o_bram_din,
   input  logic [DATA_WIDTH-1:0]   i_bram_dout,
   output logic [N*16-1:0]         o_perf_cnt,
   input  logic                    i_perf_clr
);

   localparam int PW = (N > 1) ? $clog2(N) : 1;
   localparam int BW = $clog2(MAX_BURST + 1);

   typedef enum logic [0:0] {
      IDLE   = 1'b0,
      LOCKED = 1'b1
   } state_t;

   state_t              state, state_nxt;
   logic [PW-1:0]       rr_ptr, ptr_nxt;
   logic [PW-1:0]       owner, owner_nxt;
   logic [BW-1:0]       burst_cnt, burst_nxt;
   logic [N-1:0]        gnt;
   logic                found;
   int                  win;
   int                  idx;

   logic                xfer;
   logic                mux_we;
   logic [ADDR_WIDTH-1:0] mux_addr;
   logic [DATA_WIDTH-1:0] mux_din;

   logic                bram_en, bram_we;
   logic [ADDR_WIDTH-1:0] bram_addr;
   logic [DATA_WIDTH-1:0] bram_din;
   logic [N-1:0]        rd_pend;
   logic [N-1:0]        rvalid;

   always_ff @(posedge clk) begin
      if (!i_reset_n) begin
         state     <= IDLE;
         rr_ptr    <= '0;
         owner     <= '0;
         burst_cnt <= '0;
      end else begin
         state     <= state_nxt;
         rr_ptr    <= ptr_nxt;
         owner     <= owner_nxt;
         burst_cnt <= burst_nxt;
      end
   end

   always_comb begin
      gnt       = '0;
      state_nxt = state;
      ptr_nxt   = rr_ptr;
      owner_nxt = owner;
      burst_nxt = burst_cnt;
      found     = 1'b0;
      win       = 0;
      idx       = 0;
      if (i_reset_n && i_enable) begin
         unique case (state)
            IDLE: begin
               if (i_mode) begin
                  // Exclusive: only the selected requester; pointer and lock untouched.
                  for (int k = 0; k < N; k++) begin
                     if (int'(i_sel) == k && i_req[k]) gnt[k] = 1'b1;
                  end
               end else begin
                  for (int i = 0; i < N; i++) begin
                     idx = (int'(rr_ptr) + i) % N;
                     if (!found && i_req[idx]) begin
                        found = 1'b1;
                        win   = idx;
                     end
                  end
                  if (found) begin
                     gnt[win] = 1'b1;
                     ptr_nxt  = PW'((win + 1) % N);
                     if (i_lock[win] && MAX_BURST > 1) begin
                        state_nxt = LOCKED;
                        owner_nxt = PW'(win);
                        burst_nxt = BW'(1);
                     end
                  end
               end
            end
            LOCKED: begin
               // Release cycles never grant; others compete from the next cycle.
               if (i_mode || !i_req[owner]) begin
                  state_nxt = IDLE;
                  burst_nxt = '0;
               end else begin
                  gnt[owner] = 1'b1;
                  burst_nxt  = burst_cnt + BW'(1);
                  if (!i_lock[owner] || int'(burst_cnt) + 1 >= MAX_BURST) begin
                     state_nxt = IDLE;
                     burst_nxt = '0;
                  end
               end
            end
            default: state_nxt = IDLE;
         endcase
      end
   end

   always_comb begin
      mux_we   = 1'b0;
      mux_addr = '0;
      mux_din  = '0;
      for (int k = 0; k < N; k++) begin
         if (gnt[k]) begin
            mux_we   = i_we[k];
            mux_addr = i_addr[k*ADDR_WIDTH +: ADDR_WIDTH];
            mux_din  = i_data[k*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   assign xfer = |gnt;

   always_ff @(posedge clk) begin
      if (!i_reset_n) begin
         bram_en   <= 1'b0;
         bram_we   <= 1'b0;
         bram_addr <= '0;
         bram_din  <= '0;
         rd_pend   <= '0;
         rvalid    <= '0;
      end else begin
         bram_en <= xfer;
         bram_we <= xfer & mux_we;
         if (xfer) begin
            bram_addr <= mux_addr;
            bram_din  <= mux_din;
         end
         // Tag follows the read through the BRAM's one-cycle latency.
         rd_pend <= gnt & ~i_we;
         rvalid  <= rd_pend;
      end
   end

   assign o_gnt       = gnt;
   assign o_rvalid    = rvalid;
   assign o_rdata     = i_bram_dout;
   assign o_bram_en   = bram_en;
   assign o_bram_we   = bram_we;
   assign o_bram_addr = bram_addr;
   assign o_bram_din  = bram_din;

`ifdef ARB_PERF_CNT_EN
   generate
      for (genvar k = 0; k < N; k++) begin : g_perf
         logic [15:0] cnt;
         always_ff @(posedge clk) begin
            if (!i_reset_n || i_perf_clr) begin
               cnt <= '0;
            end else if (gnt[k] && cnt != 16'hFFFF) begin
               cnt <= cnt + 16'd1;
            end
         end
         assign o_perf_cnt[k*16 +: 16] = cnt;
      end
   endgenerate
`else
   logic unused_perf_clr;
   assign unused_perf_clr = i_perf_clr;
   assign o_perf_cnt      = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_bram_port_arbiter.sv
// +----------------------------------------------------------------------------+
// | tb_bram_port_arbiter: directed self-checking bench for bram_port_arbiter.   |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_bram_port_arbiter;

   localparam int N  = 3;
   localparam int AW = 17;
   localparam int DW = 12;

   logic            clk = 1'b0;
   logic            i_reset_n;
   logic            i_enable;
   logic            i_mode;
   logic [1:0]      i_sel;
   logic [N-1:0]    i_req, i_we, i_lock;
   logic [N*AW-1:0] i_addr;
   logic [N*DW-1:0] i_data;
   logic [N-1:0]    o_gnt, o_rvalid;
   logic [DW-1:0]   o_rdata;
   logic            o_bram_en, o_bram_we;
   logic [AW-1:0]   o_bram_addr;
   logic [DW-1:0]   o_bram_din;
   logic [DW-1:0]   i_bram_dout;
   logic [N*16-1:0] o_perf_cnt;
   logic            i_perf_clr;

   int checks = 0;
   int errors = 0;

   bram_port_arbiter dut (
      .clk         (clk),
      .i_reset_n   (i_reset_n),
      .i_enable    (i_enable),
      .i_mode      (i_mode),
      .i_sel       (i_sel),
      .i_req       (i_req),
      .i_we        (i_we),
      .i_lock      (i_lock),
      .i_addr      (i_addr),
      .i_data      (i_data),
      .o_gnt       (o_gnt),
      .o_rvalid    (o_rvalid),
      .o_rdata     (o_rdata),
      .o_bram_en   (o_bram_en),
      .o_bram_we   (o_bram_we),
      .o_bram_addr (o_bram_addr),
      .o_bram_din  (o_bram_din),
      .i_bram_dout (i_bram_dout),
      .o_perf_cnt  (o_perf_cnt),
      .i_perf_clr  (i_perf_clr)
   );

   always #5 clk = ~clk;

   // Small read-first BRAM model on the low address bits.
   logic [DW-1:0] mem [0:255];
   always @(posedge clk) begin
      if (o_bram_en) begin
         if (o_bram_we) mem[o_bram_addr[7:0]] <= o_bram_din;
         else           i_bram_dout <= mem[o_bram_addr[7:0]];
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic settle();
      #1;
   endtask

   logic [2:0] exp_gnt [0:3];

   initial begin
      for (int a = 0; a < 256; a++) mem[a] = '0;
      i_bram_dout = '0;
      i_reset_n = 1'b0; i_enable = 1'b1; i_mode = 1'b0; i_sel = 2'd0;
      i_req = 3'b111; i_we = 3'b111; i_lock = '0; i_perf_clr = 1'b0;
      for (int k = 0; k < N; k++) begin
         i_addr[k*AW +: AW] = AW'(17'h100 + k);
         i_data[k*DW +: DW] = DW'(12'h010 + k);
      end

      // Reset state
      tick(); tick();
      chk("rst_gnt", o_gnt, 0);
      chk("rst_en", o_bram_en, 0);
      chk("rst_we", o_bram_we, 0);
      chk("rst_addr", o_bram_addr, 0);
      chk("rst_din", o_bram_din, 0);
      chk("rst_rvalid", o_rvalid, 0);

      // Round-robin writes with all three requesting
      i_reset_n = 1'b1;
      exp_gnt[0] = 3'b001; exp_gnt[1] = 3'b010; exp_gnt[2] = 3'b100; exp_gnt[3] = 3'b001;
      for (int c = 0; c < 4; c++) begin
         settle();
         chk("rr_gnt", o_gnt, exp_gnt[c]);
         tick();
         chk("rr_en", o_bram_en, 1);
         chk("rr_we", o_bram_we, 1);
         chk("rr_addr", o_bram_addr, (c == 1) ? 17'h101 : (c == 2) ? 17'h102 : 17'h100);
         chk("rr_din", o_bram_din, (c == 1) ? 12'h011 : (c == 2) ? 12'h012 : 12'h010);
      end
      i_req = '0;
      tick();
      chk("idle_en", o_bram_en, 0);
      chk("idle_we", o_bram_we, 0);
      chk("idle_addr_hold", o_bram_addr, 17'h100);

      // Write 0xABC to 0x10 from requester 0, then read it back
      i_req = 3'b001; i_we = 3'b001;
      i_addr[0 +: AW] = 17'h00010; i_data[0 +: DW] = 12'hABC;
      settle();
      chk("wr_gnt", o_gnt, 3'b001);
      tick();
      chk("wr_en", o_bram_en, 1);
      chk("wr_we", o_bram_we, 1);
      i_we = 3'b000;
      settle();
      chk("rd_gnt", o_gnt, 3'b001);
      tick();
      i_req = '0;
      chk("rd_en", o_bram_en, 1);
      chk("rd_we", o_bram_we, 0);
      chk("rd_addr", o_bram_addr, 17'h00010);
      chk("rd_rvalid_t1", o_rvalid, 0);
      tick();
      chk("rd_rvalid_t2", o_rvalid, 3'b001);
      chk("rd_rdata", o_rdata, 12'hABC);
      tick();
      chk("rd_rvalid_t3", o_rvalid, 0);

      // Move pointer to 2 with one grant to requester 1
      i_req = 3'b010; i_we = 3'b111;
      settle();
      chk("ptr_gnt", o_gnt, 3'b010);
      tick();

      // Locked burst: requester 2 limited to 16 accepts, then requester 1
      i_req = 3'b110; i_lock = 3'b100;
      for (int c = 0; c < 16; c++) begin
         settle();
         chk($sformatf("lock_gnt%0d", c), o_gnt, 3'b100);
         tick();
      end
      settle();
      chk("lock_after", o_gnt, 3'b010);
      tick();
      i_req = '0; i_lock = '0;
      tick();

      // Exclusive mode selects requester 1; pointer stays at 2
      i_mode = 1'b1; i_sel = 2'd1; i_req = 3'b111;
      for (int c = 0; c < 3; c++) begin
         settle();
         chk("excl_gnt", o_gnt, 3'b010);
         tick();
      end
      i_sel = 2'd3;
      settle();
      chk("excl_sel_oor", o_gnt, 0);
      tick();
      i_mode = 1'b0;
      settle();
      chk("resume_rr0", o_gnt, 3'b100);
      tick();
      chk("resume_rr1", o_gnt, 3'b001);
      tick();

      // Enable gating
      i_req = 3'b010;
      i_enable = 1'b0;
      settle();
      chk("en_low_gnt", o_gnt, 0);
      tick();
      chk("en_low_bram", o_bram_en, 0);
      i_enable = 1'b1;
      settle();
      chk("en_high_gnt", o_gnt, 3'b010);
      tick();
      chk("en_high_bram", o_bram_en, 1);
      i_enable = 1'b0;
      settle();
      chk("en_low2_gnt", o_gnt, 0);
      tick();
      i_enable = 1'b1;

      // Reset in the middle of a read
      i_we = 3'b000;
      settle();
      chk("mid_gnt", o_gnt, 3'b010);
      tick();
      i_reset_n = 1'b0; i_req = 3'b111;
      settle();
      chk("mid_rst_gnt", o_gnt, 0);
      tick();
      chk("mid_rvalid", o_rvalid, 0);
      chk("mid_en", o_bram_en, 0);
      chk("mid_addr", o_bram_addr, 0);
      chk("mid_din", o_bram_din, 0);
      i_reset_n = 1'b1; i_req = 3'b010;
      settle();
      chk("post_rst_gnt", o_gnt, 3'b010);

      // Accept counters
      for (int c = 0; c < 5; c++) tick();
      i_req = '0;
`ifdef ARB_PERF_CNT_EN
      chk("perf_cnt1", o_perf_cnt[31:16], 16'd5);
      i_perf_clr = 1'b1;
      tick();
      i_perf_clr = 1'b0;
      chk("perf_clr", o_perf_cnt[31:16], 16'd0);
`else
      chk("perf_off", o_perf_cnt, 0);
`endif
      tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      errors++;
      $display("FAIL timeout observed=running expected=finished");
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $fatal(1, "timeout");
   end

endmodule

`default_nettype wire
